// File: rtl/axil_slave_regmem_if.sv
// AXI4-Lite bus bundle between a master and the register memory slave.
interface axil_slave_regmem_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_slave_regmem.sv
// AXI4-Lite slave register memory: DEPTH x 32-bit words, byte strobes,
// SLVERR for out-of-range addresses, independent write and read FSMs.
module axil_slave_regmem #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  axil_slave_regmem_if.slave  s_axi
);

  localparam int unsigned IDX_W       = $clog2(DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  logic [31:0]       r_mem [DEPTH];

  // write path state
  wstate_t           r_wstate, w_wstate_n;
  logic              r_aw_held, w_aw_held_n;
  logic              r_w_held, w_w_held_n;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_awready, w_awready_n;
  logic              r_wready, w_wready_n;
  logic              r_bvalid, w_bvalid_n;
  logic [1:0]        r_bresp, w_bresp_n;
  logic              w_commit;

  // read path state
  rstate_t           r_rstate, w_rstate_n;
  logic              r_arready, w_arready_n;
  logic              r_rvalid, w_rvalid_n;
  logic [31:0]       r_rdata, w_rdata_n;
  logic [1:0]        r_rresp, w_rresp_n;

  logic              w_aw_hs, w_w_hs, w_ar_hs;
  logic [ADDR_W-1:0] w_aw_addr;
  logic [31:0]       w_wr_data;
  logic [3:0]        w_wr_strb;
  logic [IDX_W-1:0]  w_aw_idx, w_ar_idx;
  logic              w_aw_in_range, w_ar_in_range;
  logic              w_unused;

  assign w_aw_hs = s_axi.awvalid & r_awready;
  assign w_w_hs  = s_axi.wvalid & r_wready;
  assign w_ar_hs = s_axi.arvalid & r_arready;

  // live bus values win for the channel handshaking on the commit edge
  assign w_aw_addr = w_aw_hs ? s_axi.awaddr : r_awaddr;
  assign w_wr_data = w_w_hs ? s_axi.wdata : r_wdata;
  assign w_wr_strb = w_w_hs ? s_axi.wstrb : r_wstrb;

  assign w_aw_idx      = w_aw_addr[IDX_W+1:2];
  assign w_aw_in_range = (w_aw_addr[ADDR_W-1:IDX_W+2] == '0);
  assign w_ar_idx      = s_axi.araddr[IDX_W+1:2];
  assign w_ar_in_range = (s_axi.araddr[ADDR_W-1:IDX_W+2] == '0);

  // byte-lane offset bits are intentionally ignored
  assign w_unused = ^{w_aw_addr[1:0], s_axi.araddr[1:0]};

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  // write FSM next-state: collect AW and W in any order, commit on the second
  always_comb begin
    w_wstate_n  = r_wstate;
    w_aw_held_n = r_aw_held;
    w_w_held_n  = r_w_held;
    w_awready_n = r_awready;
    w_wready_n  = r_wready;
    w_bvalid_n  = r_bvalid;
    w_bresp_n   = r_bresp;
    w_commit    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_aw_held_n = r_aw_held | w_aw_hs;
        w_w_held_n  = r_w_held | w_w_hs;
        if (w_aw_held_n && w_w_held_n) begin
          w_commit    = 1'b1;
          w_wstate_n  = W_RESP;
          w_bvalid_n  = 1'b1;
          w_bresp_n   = w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
          w_awready_n = 1'b0;
          w_wready_n  = 1'b0;
        end else begin
          w_awready_n = !w_aw_held_n;
          w_wready_n  = !w_w_held_n;
        end
      end
      W_RESP: begin
        if (r_bvalid && s_axi.bready) begin
          w_wstate_n  = W_IDLE;
          w_bvalid_n  = 1'b0;
          w_aw_held_n = 1'b0;
          w_w_held_n  = 1'b0;
          w_awready_n = 1'b1;
          w_wready_n  = 1'b1;
        end
      end
      default: w_wstate_n = W_IDLE;
    endcase
  end

  // write FSM registers and channel holding registers
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
    end else begin
      r_wstate  <= w_wstate_n;
      r_aw_held <= w_aw_held_n;
      r_w_held  <= w_w_held_n;
      r_awready <= w_awready_n;
      r_wready  <= w_wready_n;
      r_bvalid  <= w_bvalid_n;
      r_bresp   <= w_bresp_n;
      if (w_aw_hs) r_awaddr <= s_axi.awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
      end
    end
  end

  // storage array: cleared on reset, byte-strobed update on an in-range commit
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_commit && w_aw_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) r_mem[w_aw_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  // read FSM next-state: capture word on AR handshake, hold until R handshake
  always_comb begin
    w_rstate_n  = r_rstate;
    w_arready_n = r_arready;
    w_rvalid_n  = r_rvalid;
    w_rdata_n   = r_rdata;
    w_rresp_n   = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        w_arready_n = 1'b1;
        if (w_ar_hs) begin
          w_rstate_n  = R_DATA;
          w_arready_n = 1'b0;
          w_rvalid_n  = 1'b1;
          w_rdata_n   = w_ar_in_range ? r_mem[w_ar_idx] : 32'h0;
          w_rresp_n   = w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (r_rvalid && s_axi.rready) begin
          w_rstate_n  = R_IDLE;
          w_rvalid_n  = 1'b0;
          w_arready_n = 1'b1;
        end
      end
      default: w_rstate_n = R_IDLE;
    endcase
  end

  // read FSM registers
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
    end else begin
      r_rstate  <= w_rstate_n;
      r_arready <= w_arready_n;
      r_rvalid  <= w_rvalid_n;
      r_rdata   <= w_rdata_n;
      r_rresp   <= w_rresp_n;
    end
  end

endmodule

// File: tb/tb_axil_slave_regmem.sv
// Directed self-checking bench for axil_slave_regmem (ADDR_W=32, DEPTH=32).
module tb_axil_slave_regmem;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   b_pulses = 0;
  logic prev_b = 1'b0;

  axil_slave_regmem_if #(.ADDR_W(32)) bus ();

  axil_slave_regmem #(.ADDR_W(32), .DEPTH(32)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .s_axi        (bus.slave)
  );

  always #5 clk = ~clk;

  // count rising edges of bvalid
  always @(negedge clk) begin
    prev_b <= bus.bvalid;
    if (bus.bvalid && !prev_b) b_pulses <= b_pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // full write transaction with bready held high; called and returns at a negedge
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, hs_aw, hs_w, got;
    resp = 2'b11;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data;  bus.wstrb = strb; bus.wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (hs_aw) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1'b1;  bus.wvalid = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("FAIL write_accept timeout addr=%h got aw=%b w=%b required 1 1", addr, aw_done, w_done);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bus.bvalid && bus.bready) begin resp = bus.bresp; got = 1'b1; end
      @(negedge clk);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL write_resp timeout addr=%h got bvalid=0 required 1", addr);
    end
  endtask

  // full read transaction with rready held high; called and returns at a negedge
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic done, hs;
    data = 32'hDEAD_0BAD; resp = 2'b11;
    bus.araddr = addr; bus.arvalid = 1'b1; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      hs = bus.arvalid && bus.arready;
      @(negedge clk);
      if (hs) begin done = 1'b1; bus.arvalid = 1'b0; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_accept timeout addr=%h got arready=0 required 1", addr);
      bus.arvalid = 1'b0;
      return;
    end
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (bus.rvalid && bus.rready) begin data = bus.rdata; resp = bus.rresp; done = 1'b1; end
      @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_data timeout addr=%h got rvalid=0 required 1", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got %b required 00000",
        {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}); end
    checks++; if ({bus.rdata, bus.bresp, bus.rresp} !== 36'h0) begin
      errors++; $display("FAIL reset_data got %h required 0", {bus.rdata, bus.bresp, bus.rresp}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready got %b required 111",
        {bus.awready, bus.wready, bus.arready}); end
  endtask

  task automatic test_basic_write();
    logic [31:0] d; logic [1:0] r;
    bus.awaddr = 32'h08; bus.awvalid = 1'b1;
    bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++; if ({bus.awready, bus.wready, bus.bvalid, bus.bresp} !== 5'b00100) begin
      errors++; $display("FAIL basic_commit got aw/w/bv/bresp=%b required 00100",
        {bus.awready, bus.wready, bus.bvalid, bus.bresp}); end
    @(negedge clk);
    checks++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
      errors++; $display("FAIL basic_bdone got bv/aw/w=%b required 011",
        {bus.bvalid, bus.awready, bus.wready}); end
    axi_read(32'h08, d, r);
    checks++; if ({d, r} !== {32'h5, 2'b00}) begin
      errors++; $display("FAIL basic_read got %h/%b required 00000005/00", d, r); end
  endtask

  task automatic test_w_first();
    logic [31:0] d; logic [1:0] r;
    bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    checks++; if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin
      errors++; $display("FAIL wfirst_held got w/aw/bv=%b required 010",
        {bus.wready, bus.awready, bus.bvalid}); end
    @(negedge clk); @(negedge clk);
    checks++; if ({bus.wready, bus.bvalid} !== 2'b00) begin
      errors++; $display("FAIL wfirst_wait got w/bv=%b required 00", {bus.wready, bus.bvalid}); end
    bus.awaddr = 32'h04; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    checks++; if ({bus.bvalid, bus.bresp} !== 3'b100) begin
      errors++; $display("FAIL wfirst_commit got bv/bresp=%b required 100", {bus.bvalid, bus.bresp}); end
    @(negedge clk);
    axi_write(32'h04, 32'h11223344, 4'b0101, r);
    checks++; if (r !== 2'b00) begin
      errors++; $display("FAIL strobe_bresp got %b required 00", r); end
    axi_read(32'h04, d, r);
    checks++; if ({d, r} !== {32'hAA22CC44, 2'b00}) begin
      errors++; $display("FAIL strobe_read got %h/%b required aa22cc44/00", d, r); end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h84, 32'hDEADBEEF, 4'hF, r);
    checks++; if (r !== 2'b10) begin
      errors++; $display("FAIL oor_bresp got %b required 10", r); end
    axi_read(32'h84, d, r);
    checks++; if ({d, r} !== {32'h0, 2'b10}) begin
      errors++; $display("FAIL oor_read got %h/%b required 00000000/10", d, r); end
    axi_read(32'h04, d, r);
    checks++; if (d !== 32'hAA22CC44) begin
      errors++; $display("FAIL oor_alias_w1 got %h required aa22cc44", d); end
    axi_read(32'h00, d, r);
    checks++; if (d !== 32'h0) begin
      errors++; $display("FAIL oor_alias_w0 got %h required 00000000", d); end
  endtask

  task automatic test_backpressure();
    bus.bready = 1'b0;
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      checks++; if ({bus.bvalid, bus.bresp, bus.awready} !== 4'b1000) begin
        errors++; $display("FAIL b_stall cycle %0d got bv/bresp/aw=%b required 1000", n,
          {bus.bvalid, bus.bresp, bus.awready}); end
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.bvalid, bus.awready} !== 2'b01) begin
      errors++; $display("FAIL b_release got bv/aw=%b required 01", {bus.bvalid, bus.awready}); end
    bus.rready = 1'b0;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      checks++; if ({bus.rvalid, bus.rdata, bus.rresp, bus.arready} !== {1'b1, 32'h12345678, 3'b000}) begin
        errors++; $display("FAIL r_stall cycle %0d got rv=%b rdata=%h rresp=%b ar=%b required 1 12345678 00 0",
          n, bus.rvalid, bus.rdata, bus.rresp, bus.arready); end
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.rvalid, bus.arready} !== 2'b01) begin
      errors++; $display("FAIL r_release got rv/ar=%b required 01", {bus.rvalid, bus.arready}); end
  endtask

  task automatic test_unaligned();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h13, 32'h7, 4'hF, r);
    checks++; if (r !== 2'b00) begin
      errors++; $display("FAIL unaligned_bresp got %b required 00", r); end
    axi_read(32'h10, d, r);
    checks++; if ({d, r} !== {32'h7, 2'b00}) begin
      errors++; $display("FAIL unaligned_read got %h/%b required 00000007/00", d, r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h00, 32'h08, 32'h10, 32'h04};
    logic [31:0] raddr [6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    logic [31:0] rexp  [6] = '{32'd7, 32'd10, 32'd8, 32'd4, 32'd9, 32'd6};
    logic [31:0] d; logic [1:0] r; int start;
    #1 start = b_pulses;
    for (int i = 0; i < 10; i++) begin
      axi_write(addrs[i], 32'(i + 1), 4'hF, r);
      checks++; if (r !== 2'b00) begin
        errors++; $display("FAIL b2b_bresp %0d got %b required 00", i, r); end
    end
    #1;
    checks++; if (b_pulses - start !== 10) begin
      errors++; $display("FAIL b2b_pulses got %0d required 10", b_pulses - start); end
    for (int i = 0; i < 6; i++) begin
      axi_read(raddr[i], d, r);
      checks++; if (d !== rexp[i]) begin
        errors++; $display("FAIL b2b_read %h got %h required %h", raddr[i], d, rexp[i]); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r;
    bus.awaddr = 32'h14; bus.awvalid = 1'b1;
    bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 32'h14; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checks++; if ({bus.rvalid, bus.bvalid, bus.rdata} !== {2'b11, 32'h6}) begin
      errors++; $display("FAIL collide_old got rv=%b bv=%b rdata=%h required 1 1 00000006",
        bus.rvalid, bus.bvalid, bus.rdata); end
    @(negedge clk);
    axi_read(32'h14, d, r);
    checks++; if (d !== 32'hCAFEF00D) begin
      errors++; $display("FAIL collide_new got %h required cafef00d", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 32'h00; bus.awvalid = 1'b1;
    bus.wdata = 32'hFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 32'h14; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checks++; if ({bus.bvalid, bus.rvalid} !== 2'b11) begin
      errors++; $display("FAIL mid_pending got bv/rv=%b required 11", {bus.bvalid, bus.rvalid}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.bvalid, bus.rvalid, bus.awready, bus.arready} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset got bv/rv/aw/ar=%b required 0000",
        {bus.bvalid, bus.rvalid, bus.awready, bus.arready}); end
    rst = 1'b0; bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++; $display("FAIL mid_release got aw/w/ar=%b required 111",
        {bus.awready, bus.wready, bus.arready}); end
    axi_read(32'h00, d, r);
    checks++; if (d !== 32'h0) begin
      errors++; $display("FAIL mid_mem0 got %h required 00000000", d); end
    axi_read(32'h14, d, r);
    checks++; if (d !== 32'h0) begin
      errors++; $display("FAIL mid_mem5 got %h required 00000000", d); end
  endtask

  initial begin
    rst = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    test_reset();
    test_basic_write();
    test_w_first();
    test_slverr();
    test_backpressure();
    test_unaligned();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
